// File: rtl/mux8_row_loader_pkg.sv
// Shared types and constants for the 8x8 row loader and its tag decoder.
package mux8_row_loader_pkg;

    localparam int unsigned W        = 32;
    localparam int unsigned N        = 8;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned LAST_IDX = 63;

    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/mux8_row_loader_tag_decoder.sv
// Row index to one-hot tag decoder; all tags low when not enabled.
// Ports: row (binary active row), en (presenting), tag (one-hot out).
module mux8_tag_decoder
    import mux8_row_loader_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    input  logic             en,
    output logic [N-1:0]     tag
);

    always_comb begin
        tag = '0;
        if (en) begin
            tag[row] = 1'b1;
        end
    end

endmodule

// File: rtl/mux8_row_loader.sv
// Loads 64 words row-major into an 8x8 matrix, then presents it one
// tagged row per downstream handshake before returning to load.
// Ports: clock/reset (async active-high), in_valid/in_ready/in_data
// upstream stream, io_int_in_r_c matrix words, io_tag_0..7 one-hot
// row tags, out_valid/out_ready downstream handshake, row_idx trace.
module mux8_row_loader
    import mux8_row_loader_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     io_int_in_0_0, io_int_in_0_1, io_int_in_0_2, io_int_in_0_3,
    output logic [W-1:0]     io_int_in_0_4, io_int_in_0_5, io_int_in_0_6, io_int_in_0_7,
    output logic [W-1:0]     io_int_in_1_0, io_int_in_1_1, io_int_in_1_2, io_int_in_1_3,
    output logic [W-1:0]     io_int_in_1_4, io_int_in_1_5, io_int_in_1_6, io_int_in_1_7,
    output logic [W-1:0]     io_int_in_2_0, io_int_in_2_1, io_int_in_2_2, io_int_in_2_3,
    output logic [W-1:0]     io_int_in_2_4, io_int_in_2_5, io_int_in_2_6, io_int_in_2_7,
    output logic [W-1:0]     io_int_in_3_0, io_int_in_3_1, io_int_in_3_2, io_int_in_3_3,
    output logic [W-1:0]     io_int_in_3_4, io_int_in_3_5, io_int_in_3_6, io_int_in_3_7,
    output logic [W-1:0]     io_int_in_4_0, io_int_in_4_1, io_int_in_4_2, io_int_in_4_3,
    output logic [W-1:0]     io_int_in_4_4, io_int_in_4_5, io_int_in_4_6, io_int_in_4_7,
    output logic [W-1:0]     io_int_in_5_0, io_int_in_5_1, io_int_in_5_2, io_int_in_5_3,
    output logic [W-1:0]     io_int_in_5_4, io_int_in_5_5, io_int_in_5_6, io_int_in_5_7,
    output logic [W-1:0]     io_int_in_6_0, io_int_in_6_1, io_int_in_6_2, io_int_in_6_3,
    output logic [W-1:0]     io_int_in_6_4, io_int_in_6_5, io_int_in_6_6, io_int_in_6_7,
    output logic [W-1:0]     io_int_in_7_0, io_int_in_7_1, io_int_in_7_2, io_int_in_7_3,
    output logic [W-1:0]     io_int_in_7_4, io_int_in_7_5, io_int_in_7_6, io_int_in_7_7,
    output logic             io_tag_0, io_tag_1, io_tag_2, io_tag_3,
    output logic             io_tag_4, io_tag_5, io_tag_6, io_tag_7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] row_idx
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row;
    logic [W-1:0]     mat [N][N];
    logic [N-1:0]     tag;

    // Load/present sequencer; the matrix is only written while loading.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
            cnt   <= '0;
            row   <= '0;
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mat[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        mat[cnt[5:3]][cnt[2:0]] <= in_data;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(LAST_IDX)) begin
                            state <= ST_PRESENT;
                            row   <= '0;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        // row wraps 7 -> 0 on the way back to LOAD
                        row <= row + ROW_W'(1);
                        if (row == ROW_W'(N - 1)) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Handshake outputs decode from state only, never from in_valid/out_ready.
    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_PRESENT);
    assign row_idx   = row;

    mux8_tag_decoder u_tag_dec (
        .row (row),
        .en  (state == ST_PRESENT),
        .tag (tag)
    );

    assign {io_tag_7, io_tag_6, io_tag_5, io_tag_4, io_tag_3, io_tag_2, io_tag_1, io_tag_0} = tag;

    assign io_int_in_0_0 = mat[0][0]; assign io_int_in_0_1 = mat[0][1]; assign io_int_in_0_2 = mat[0][2]; assign io_int_in_0_3 = mat[0][3];
    assign io_int_in_0_4 = mat[0][4]; assign io_int_in_0_5 = mat[0][5]; assign io_int_in_0_6 = mat[0][6]; assign io_int_in_0_7 = mat[0][7];
    assign io_int_in_1_0 = mat[1][0]; assign io_int_in_1_1 = mat[1][1]; assign io_int_in_1_2 = mat[1][2]; assign io_int_in_1_3 = mat[1][3];
    assign io_int_in_1_4 = mat[1][4]; assign io_int_in_1_5 = mat[1][5]; assign io_int_in_1_6 = mat[1][6]; assign io_int_in_1_7 = mat[1][7];
    assign io_int_in_2_0 = mat[2][0]; assign io_int_in_2_1 = mat[2][1]; assign io_int_in_2_2 = mat[2][2]; assign io_int_in_2_3 = mat[2][3];
    assign io_int_in_2_4 = mat[2][4]; assign io_int_in_2_5 = mat[2][5]; assign io_int_in_2_6 = mat[2][6]; assign io_int_in_2_7 = mat[2][7];
    assign io_int_in_3_0 = mat[3][0]; assign io_int_in_3_1 = mat[3][1]; assign io_int_in_3_2 = mat[3][2]; assign io_int_in_3_3 = mat[3][3];
    assign io_int_in_3_4 = mat[3][4]; assign io_int_in_3_5 = mat[3][5]; assign io_int_in_3_6 = mat[3][6]; assign io_int_in_3_7 = mat[3][7];
    assign io_int_in_4_0 = mat[4][0]; assign io_int_in_4_1 = mat[4][1]; assign io_int_in_4_2 = mat[4][2]; assign io_int_in_4_3 = mat[4][3];
    assign io_int_in_4_4 = mat[4][4]; assign io_int_in_4_5 = mat[4][5]; assign io_int_in_4_6 = mat[4][6]; assign io_int_in_4_7 = mat[4][7];
    assign io_int_in_5_0 = mat[5][0]; assign io_int_in_5_1 = mat[5][1]; assign io_int_in_5_2 = mat[5][2]; assign io_int_in_5_3 = mat[5][3];
    assign io_int_in_5_4 = mat[5][4]; assign io_int_in_5_5 = mat[5][5]; assign io_int_in_5_6 = mat[5][6]; assign io_int_in_5_7 = mat[5][7];
    assign io_int_in_6_0 = mat[6][0]; assign io_int_in_6_1 = mat[6][1]; assign io_int_in_6_2 = mat[6][2]; assign io_int_in_6_3 = mat[6][3];
    assign io_int_in_6_4 = mat[6][4]; assign io_int_in_6_5 = mat[6][5]; assign io_int_in_6_6 = mat[6][6]; assign io_int_in_6_7 = mat[6][7];
    assign io_int_in_7_0 = mat[7][0]; assign io_int_in_7_1 = mat[7][1]; assign io_int_in_7_2 = mat[7][2]; assign io_int_in_7_3 = mat[7][3];
    assign io_int_in_7_4 = mat[7][4]; assign io_int_in_7_5 = mat[7][5]; assign io_int_in_7_6 = mat[7][6]; assign io_int_in_7_7 = mat[7][7];

endmodule
